// File: rtl/mc_pwm_dac_pkg.sv
// Shared helpers for the multi-channel PWM DAC: code saturation, counter sizing,
// and the window-boundary load-source encoding.
package mc_pwm_dac_pkg;

  localparam int unsigned DEFAULT_CHANNELS = 2;
  localparam int unsigned DEFAULT_CPW      = 1024;

  // Duty values run 0..CYCLES_PER_WINDOW inclusive, so one extra code point is needed.
  localparam int unsigned DEFAULT_DUTY_W   = $clog2(DEFAULT_CPW + 1);

  typedef enum logic [1:0] {
    LOAD_NONE    = 2'd0,
    LOAD_HOLDING = 2'd1,
    LOAD_BYPASS  = 2'd2
  } load_src_e;

  function automatic int unsigned duty_width(input int unsigned cpw);
    return $clog2(cpw + 1);
  endfunction

  // Any code at or above the window length means 100% duty.
  function automatic logic [31:0] clamp_code(input logic [31:0] code, input int unsigned cpw);
    return (code >= cpw) ? cpw : code;
  endfunction

endpackage

// File: rtl/mc_pwm_dac_channel.sv
// One PWM channel: active code register, comparator against the shared window counter,
// registered output. Center-aligned pulses when MC_PWM_DAC_CENTER_ALIGN_EN is defined.
module pwm_dac_channel
  import mc_pwm_dac_pkg::*;
#(
  parameter int unsigned CYCLES_PER_WINDOW = DEFAULT_CPW,
  parameter int unsigned CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW),
  parameter int unsigned CTR_W             = $clog2(CYCLES_PER_WINDOW)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [CODE_WIDTH-1:0] code,
  input  logic [CTR_W-1:0]      ctr,
  output logic                  pwm
);

  localparam int unsigned DUTY_W = duty_width(CYCLES_PER_WINDOW);

  logic [DUTY_W-1:0] duty_next;
  logic [DUTY_W-1:0] ctr_ext;

  always_comb begin
    duty_next = DUTY_W'(clamp_code(32'(code), CYCLES_PER_WINDOW));
    ctr_ext   = DUTY_W'(ctr);
  end

`ifdef MC_PWM_DAC_CENTER_ALIGN_EN
  logic [DUTY_W-1:0] lo;
  logic [DUTY_W-1:0] hi;
  logic [DUTY_W-1:0] lo_next;
  logic [DUTY_W-1:0] hi_next;

  // An odd remainder rounds lo down, leaving the extra low cycle at the window end.
  always_comb begin
    lo_next = (DUTY_W'(CYCLES_PER_WINDOW) - duty_next) >> 1;
    hi_next = lo_next + duty_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo  <= '0;
      hi  <= '0;
      pwm <= 1'b0;
    end else begin
      if (load) begin
        lo <= lo_next;
        hi <= hi_next;
      end
      pwm <= (ctr_ext >= lo) && (ctr_ext < hi);
    end
  end
`else
  logic [DUTY_W-1:0] duty;

  // NOTE: state registers use non-blocking assignments so every channel samples the same ctr value.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      if (load) duty <= duty_next;
      pwm <= (ctr_ext < duty);
    end
  end
`endif

endmodule

// File: rtl/mc_pwm_dac.sv
// Multi-channel PWM DAC top: shared window counter, one-deep holding buffer with
// valid/ready, boundary-only code updates. Optional MC_PWM_DAC_CENTER_ALIGN_EN.
module mc_pwm_dac
  import mc_pwm_dac_pkg::*;
#(
  parameter int unsigned CHANNELS          = DEFAULT_CHANNELS,
  parameter int unsigned CYCLES_PER_WINDOW = DEFAULT_CPW,
  parameter int unsigned CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*CODE_WIDTH-1:0] sample_data,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  output logic [CHANNELS-1:0]            pwm,
  output logic                           window_start,
  output logic                           underrun
);

  localparam int unsigned      CTR_W    = $clog2(CYCLES_PER_WINDOW);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CYCLES_PER_WINDOW - 1);

  logic [CTR_W-1:0]               ctr;
  logic                           boundary;
  logic                           full;
  logic                           accept;
  logic [CHANNELS*CODE_WIDTH-1:0] holding;
  logic [CHANNELS*CODE_WIDTH-1:0] load_data;
  logic                           load;
  load_src_e                      load_src;

  always_comb begin
    boundary     = (ctr == CTR_LAST);
    sample_ready = !full && !rst;
    accept       = sample_valid && sample_ready;
    window_start = !rst && (ctr == '0);

    // A full buffer wins; otherwise a sample arriving exactly on the boundary bypasses it.
    load_src = LOAD_NONE;
    if (boundary) begin
      if (full)              load_src = LOAD_HOLDING;
      else if (sample_valid) load_src = LOAD_BYPASS;
    end

    load      = (load_src != LOAD_NONE);
    load_data = (load_src == LOAD_HOLDING) ? holding : sample_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr <= '0;
    end else if (boundary) begin
      ctr <= '0;
    end else begin
      ctr <= ctr + CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= boundary && !full && !sample_valid;
      if (boundary)    full <= 1'b0;
      else if (accept) full <= 1'b1;
    end
  end

  // NOTE: the holding data is deliberately not reset; full gates every use of it.
  always_ff @(posedge clk) begin
    if (accept && !boundary) holding <= sample_data;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_dac_channel #(
      .CYCLES_PER_WINDOW (CYCLES_PER_WINDOW),
      .CODE_WIDTH        (CODE_WIDTH),
      .CTR_W             (CTR_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .code (load_data[i*CODE_WIDTH +: CODE_WIDTH]),
      .ctr  (ctr),
      .pwm  (pwm[i])
    );
  end

endmodule

// File: tb/tb_mc_pwm_dac.sv
// Scoreboard bench for mc_pwm_dac (CHANNELS=2, CPW=16, 5-bit codes so saturation is reachable).
// Expected per-window pulse shapes are queued by stimulus and checked by a window monitor.
module tb_mc_pwm_dac;

  localparam int CH  = 2;
  localparam int CPW = 16;
  localparam int CW  = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH*CW-1:0] sample_data = '0;
  logic            sample_valid = 1'b0;
  logic            sample_ready;
  logic [CH-1:0]   pwm;
  logic            window_start;
  logic            underrun;

  mc_pwm_dac #(
    .CHANNELS          (CH),
    .CYCLES_PER_WINDOW (CPW),
    .CODE_WIDTH        (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm          (pwm),
    .window_start (window_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int n0;
    int n1;
    bit und;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected first high position (compared ctr value) of a channel with code n.
  function automatic int exp_first(input int n);
    int eff;
    eff = (n >= CPW) ? CPW : n;
    if (eff == 0) return CPW;
`ifdef MC_PWM_DAC_CENTER_ALIGN_EN
    return (CPW - eff) >> 1;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_last(input int n);
    int eff;
    eff = (n >= CPW) ? CPW : n;
    if (eff == 0) return -1;
    return exp_first(n) + eff - 1;
  endfunction

  task automatic push(input int tag, input int c1, input int c0, input bit und);
    exp_t e;
    e.tag = tag; e.n0 = c0; e.n1 = c1; e.und = und;
    sb.push_back(e);
  endtask

  // Monitor: a window's output spans the cycles after one window_start up to and
  // including the next window_start cycle (pwm lags ctr by one cycle).
  int win_idx = 0;
  bit in_prog = 0;
  int pos     = 0;
  bit cur_und = 0;
  int cnt[CH];
  int first[CH];
  int last[CH];

  task automatic accumulate(input int p);
    for (int c = 0; c < CH; c++) begin
      if (pwm[c]) begin
        cnt[c]++;
        if (first[c] == CPW) first[c] = p;
        last[c] = p;
      end
    end
  endtask

  task automatic finalize();
    int n[CH];
    if (sb.size() > 0 && sb[0].tag < win_idx) begin
      check("window_missed_tag", win_idx, sb[0].tag);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].tag == win_idx) begin
      n[0] = sb[0].n0;
      n[1] = sb[0].n1;
      check($sformatf("w%0d_underrun", win_idx), int'(cur_und), int'(sb[0].und));
      for (int c = 0; c < CH; c++) begin
        check($sformatf("w%0d_ch%0d_high_count", win_idx, c), cnt[c], (n[c] >= CPW) ? CPW : n[c]);
        check($sformatf("w%0d_ch%0d_first_high", win_idx, c), first[c], exp_first(n[c]));
        check($sformatf("w%0d_ch%0d_last_high", win_idx, c), last[c], exp_last(n[c]));
      end
      void'(sb.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      in_prog = 0;
      win_idx = 0;
    end else begin
      check("underrun_only_at_ctr0", int'(underrun && !window_start), 0);
      if (window_start) begin
        if (in_prog) begin
          accumulate(CPW - 1);
          finalize();
        end
        win_idx++;
        in_prog = 1;
        cur_und = underrun;
        pos     = 0;
        for (int c = 0; c < CH; c++) begin
          cnt[c] = 0; first[c] = CPW; last[c] = -1;
        end
      end else if (in_prog) begin
        accumulate(pos);
        pos++;
      end
    end
  end

  // Leaves the caller at negedge+1 of the cycle where ctr == c in the next window.
  task automatic goto_ctr(input int c);
    bit found = 0;
    for (int i = 0; i < 3 * CPW; i++) begin
      @(negedge clk);
      if (window_start) begin
        found = 1;
        break;
      end
    end
    check("window_start_seen", int'(found), 1);
    repeat (c) @(negedge clk);
    #1;
  endtask

  task automatic send(input int c1, input int c0, output bit first_ready, output bit ws_acc);
    bit ok = 0;
    ws_acc       = 0;
    sample_data  = {CW'(c1), CW'(c0)};
    sample_valid = 1'b1;
    first_ready  = sample_ready;
    for (int i = 0; i < 3 * CPW; i++) begin
      if (sample_ready) begin
        ws_acc = window_start;
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    check("send_accepted", int'(ok), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pwm"}, int'(pwm), 0);
    check({tag, "_ready"}, int'(sample_ready), 0);
    check({tag, "_window_start"}, int'(window_start), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
  endtask

  int vec1[9] = '{4, 4, 4, 15, 8, 6, 31, 16, 0};
  int vec0[9] = '{12, 12, 12, 1, 8, 0, 3, 5, 2};

  initial begin
    bit fr;
    bit wsa;
    int base;

    // Power-on reset.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("por");
    end
    rst = 1'b0;
    #1;
    check("por_release_window_start", int'(window_start), 1);
    check("por_release_ready", int'(sample_ready), 1);

    // Steady stream and assorted codes, one sample loaded mid-window each window.
    for (int v = 0; v < 9; v++) begin
      goto_ctr(3);
      push(win_idx + 1, vec1[v], vec0[v], 1'b0);
      send(vec1[v], vec0[v], fr, wsa);
    end

    // Underrun: one window with no sample keeps the previous codes.
    goto_ctr(3);
    push(win_idx + 1, 5, 5, 1'b0);
    push(win_idx + 2, 5, 5, 1'b1);
    send(5, 5, fr, wsa);
    goto_ctr(0);

    // Boundary bypass with empty holding buffer.
    goto_ctr(CPW - 1);
    check("bypass_ready_before", int'(sample_ready), 1);
    push(win_idx + 1, 16, 0, 1'b0);
    send(16, 0, fr, wsa);
    check("bypass_ready_after", int'(sample_ready), 1);
    check("bypass_window_start_after", int'(window_start), 1);

    // Backpressure: second sample waits for the boundary to empty the buffer.
    goto_ctr(4);
    base = win_idx;
    push(base + 1, 3, 9, 1'b0);
    push(base + 2, 10, 7, 1'b0);
    send(3, 9, fr, wsa);
    check("bp_first_ready", int'(fr), 1);
    send(10, 7, fr, wsa);
    check("bp_second_ready_initially", int'(fr), 0);
    check("bp_second_accepted_at_ctr0", int'(wsa), 1);
    goto_ctr(0);

    // Mid-window reset with a full holding buffer that must be discarded.
    goto_ctr(3);
    send(9, 9, fr, wsa);
    check("pre_reset_buffer_full", int'(sample_ready), 0);
    repeat (3) @(negedge clk);
    #1;
    check("sb_drained_before_reset", sb.size(), 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("mid_rst");
    end
    rst = 1'b0;
    #1;
    check("mid_rst_release_window_start", int'(window_start), 1);
    check("mid_rst_release_ready", int'(sample_ready), 1);
    push(1, 0, 0, 1'b0);
    push(2, 0, 0, 1'b1);
    goto_ctr(0);
    goto_ctr(0);
    goto_ctr(0);
    check("sb_drained_at_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
